// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared types and constants for the matrix instruction sequencer
//
// Contents:
//   opcode_e   : matrix ALU opcodes (values 6..15 are illegal)
//   state_e    : sequencer FSM states
//   mat_t      : 4x4 matrix of 16-bit elements packed into one 256-bit bus word
//   bus region / ALU offset constants used to build bus addresses
//   op_legal() : opcode legality check
package matrix_pkg;

  typedef enum logic [3:0] {
    OP_MULTIPLY = 4'd0,
    OP_ADD      = 4'd1,
    OP_SUBTRACT = 4'd2,
    OP_TRANSPOSE = 4'd3,
    OP_SCALE    = 4'd4,
    OP_SCALEIMM = 4'd5
  } opcode_e;

  // Upper address nibble selects the bus target.
  localparam logic [3:0] MEM_REGION = 4'h1;
  localparam logic [3:0] ALU_REGION = 4'h2;

  // Low address nibble within the ALU region.
  localparam logic [3:0] SRC1   = 4'h0;
  localparam logic [3:0] SRC2   = 4'h1;
  localparam logic [3:0] RESULT = 4'h2;
  localparam logic [3:0] EXEC   = 4'h3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD1,
    S_CAP1,
    S_LD1,
    S_RD2,
    S_CAP2,
    S_LD2,
    S_EXEC,
    S_RDR,
    S_CAPR,
    S_WRM,
    S_DONE
  } state_e;

  typedef logic [3:0][3:0][15:0] mat_t;

  function automatic logic op_legal(input logic [3:0] op);
    return (op <= 4'(OP_SCALEIMM));
  endfunction

endpackage

// File: rtl/matrix_exec_seq.sv
// rtl/matrix_exec_seq.sv - sequencer moving operands between main memory and the matrix ALU
//
// Accepts one matrix instruction at a time, copies src1 (and src2) from main
// memory into the ALU source registers, triggers the ALU, reads the result and
// writes it back to main memory over the shared 16-bit address / 256-bit data bus.
//
// Ports:
//   Clk, nReset            : clock (rising edge), asynchronous active-low reset
//   inst_valid/inst_ready  : instruction handshake (ready only in IDLE)
//   inst_op/src1/src2/dest : opcode and 12-bit main-memory word addresses
//   inst_imm               : immediate scale factor (used only with MATRIX_SEQ_IMM_EN)
//   address/nRead/nWrite   : bus address and active-low strobes
//   ExeDataOut             : bus write data
//   MemDataOut             : main-memory read data
//   MatrixDataOut          : ALU result read data
//   done/err/busy          : completion pulse, illegal-opcode flag, not-idle status
//
// Build option MATRIX_SEQ_IMM_EN: SCALEIMMEDIATE loads inst_imm into ALU src2
// instead of reading src2 from memory.
module matrix_exec_seq
  import matrix_pkg::*;
(
  input  logic         Clk,
  input  logic         nReset,
  input  logic         inst_valid,
  output logic         inst_ready,
  input  logic [3:0]   inst_op,
  input  logic [11:0]  inst_src1,
  input  logic [11:0]  inst_src2,
  input  logic [11:0]  inst_dest,
  input  logic [15:0]  inst_imm,
  output logic [15:0]  address,
  output logic         nRead,
  output logic         nWrite,
  output logic [255:0] ExeDataOut,
  input  logic [255:0] MemDataOut,
  input  logic [255:0] MatrixDataOut,
  output logic         done,
  output logic         err,
  output logic         busy
);

  state_e      state, state_nxt;
  logic [3:0]  op_q;
  logic [11:0] src1_q, src2_q, dest_q;
  mat_t        data_buf;
  logic        accept;

`ifdef MATRIX_SEQ_IMM_EN
  logic [15:0] imm_q;
`else
  logic        imm_unused;
  assign imm_unused = ^inst_imm;
`endif

  assign inst_ready = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign accept     = inst_valid && inst_ready;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      op_q     <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      dest_q   <= '0;
      data_buf <= '0;
`ifdef MATRIX_SEQ_IMM_EN
      imm_q    <= '0;
`endif
    end else begin
      if (accept) begin
        op_q   <= inst_op;
        src1_q <= inst_src1;
        src2_q <= inst_src2;
        dest_q <= inst_dest;
`ifdef MATRIX_SEQ_IMM_EN
        imm_q  <= inst_imm;
`endif
      end
      // Memory and ALU both return read data the cycle after the read strobe.
      if (state == S_CAP1 || state == S_CAP2) begin
        data_buf <= MemDataOut;
      end else if (state == S_CAPR) begin
        data_buf <= MatrixDataOut;
      end
    end
  end

  // Bus outputs decode only the state register and latched instruction fields,
  // so an asynchronous reset idles the bus immediately.
  always_comb begin
    state_nxt  = state;
    address    = 16'h0000;
    nRead      = 1'b1;
    nWrite     = 1'b1;
    ExeDataOut = '0;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      S_IDLE: begin
        if (inst_valid) begin
          state_nxt = op_legal(inst_op) ? S_RD1 : S_DONE;
        end
      end
      S_RD1: begin
        nRead     = 1'b0;
        address   = {MEM_REGION, src1_q};
        state_nxt = S_CAP1;
      end
      S_CAP1: begin
        state_nxt = S_LD1;
      end
      S_LD1: begin
        nWrite     = 1'b0;
        address    = {ALU_REGION, 8'h00, SRC1};
        ExeDataOut = data_buf;
        if (op_q == OP_TRANSPOSE) begin
          state_nxt = S_EXEC;
`ifdef MATRIX_SEQ_IMM_EN
        end else if (op_q == OP_SCALEIMM) begin
          state_nxt = S_LD2;
`endif
        end else begin
          state_nxt = S_RD2;
        end
      end
      S_RD2: begin
        nRead     = 1'b0;
        address   = {MEM_REGION, src2_q};
        state_nxt = S_CAP2;
      end
      S_CAP2: begin
        state_nxt = S_LD2;
      end
      S_LD2: begin
        nWrite     = 1'b0;
        address    = {ALU_REGION, 8'h00, SRC2};
        ExeDataOut = data_buf;
`ifdef MATRIX_SEQ_IMM_EN
        if (op_q == OP_SCALEIMM) begin
          ExeDataOut = {240'b0, imm_q};
        end
`endif
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        address   = {ALU_REGION, 4'h0, op_q, EXEC};
        state_nxt = S_RDR;
      end
      S_RDR: begin
        nRead     = 1'b0;
        address   = {ALU_REGION, 8'h00, RESULT};
        state_nxt = S_CAPR;
      end
      S_CAPR: begin
        state_nxt = S_WRM;
      end
      S_WRM: begin
        nWrite     = 1'b0;
        address    = {MEM_REGION, dest_q};
        ExeDataOut = data_buf;
        state_nxt  = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        err       = !op_legal(op_q);
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_matrix_exec_seq.sv
// tb/tb_matrix_exec_seq.sv - directed self-checking bench for matrix_exec_seq
module tb_matrix_exec_seq;
  import matrix_pkg::*;

  logic         Clk = 1'b0;
  logic         nReset = 1'b1;
  logic         inst_valid;
  logic         inst_ready;
  logic [3:0]   inst_op;
  logic [11:0]  inst_src1, inst_src2, inst_dest;
  logic [15:0]  inst_imm;
  logic [15:0]  address;
  logic         nRead, nWrite;
  logic [255:0] ExeDataOut;
  logic [255:0] MemDataOut = '0;
  logic [255:0] MatrixDataOut = '0;
  logic         done, err, busy;

  matrix_exec_seq dut (
    .Clk(Clk), .nReset(nReset),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_op(inst_op), .inst_src1(inst_src1), .inst_src2(inst_src2),
    .inst_dest(inst_dest), .inst_imm(inst_imm),
    .address(address), .nRead(nRead), .nWrite(nWrite),
    .ExeDataOut(ExeDataOut), .MemDataOut(MemDataOut),
    .MatrixDataOut(MatrixDataOut),
    .done(done), .err(err), .busy(busy)
  );

  always #5 Clk = ~Clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic mat_t fill_mat(input logic [15:0] v);
    mat_t m;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[r][c] = v;
    return m;
  endfunction

  // Bus-side models: main memory and matrix ALU, both with one-cycle read latency.
  logic [255:0] mem [0:4095];
  mat_t alu_a = '0, alu_b = '0, alu_r = '0;

  function automatic mat_t alu_calc(input logic [3:0] op, input mat_t a, input mat_t b);
    mat_t r = '0;
    logic [15:0] acc;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        case (op)
          4'd0: begin
            acc = '0;
            for (int k = 0; k < 4; k++) acc = acc + 16'(a[i][k] * b[k][j]);
            r[i][j] = acc;
          end
          4'd1: r[i][j] = a[i][j] + b[i][j];
          4'd2: r[i][j] = a[i][j] - b[i][j];
          4'd3: r[i][j] = a[j][i];
          4'd4, 4'd5: r[i][j] = 16'(a[i][j] * b[0][0]);
          default: r[i][j] = '0;
        endcase
      end
    return r;
  endfunction

  always @(posedge Clk) begin
    if (!nRead && address[15:12] == 4'h1) MemDataOut <= mem[address[11:0]];
    if (!nWrite && address[15:12] == 4'h1) mem[address[11:0]] = ExeDataOut;
    if (!nWrite && address == 16'h2000) alu_a <= ExeDataOut;
    if (!nWrite && address == 16'h2001) alu_b <= ExeDataOut;
    if (nRead && nWrite && address[15:12] == 4'h2 && address[3:0] == 4'h3)
      alu_r <= alu_calc(address[7:4], alu_a, alu_b);
    if (!nRead && address == 16'h2002) MatrixDataOut <= alu_r;
  end

  // Bus trace and protocol monitor, sampled mid-cycle.
  logic [15:0]  trace [$];
  logic [255:0] ld2_data;
  int           bus_viol = 0;

  always @(negedge Clk) begin
    if (!nRead || !nWrite || address != 16'h0000) trace.push_back(address);
    if (!nWrite && address == 16'h2001) ld2_data = ExeDataOut;
    if ((!nRead && !nWrite) || (nWrite && ExeDataOut != '0)) bus_viol++;
  end

  function automatic logic [255:0] trace_vec();
    logic [255:0] v = '0;
    foreach (trace[i]) v = {v[239:0], trace[i]};
    return v;
  endfunction

  task automatic run_inst(input logic [3:0] op, input logic [11:0] s1, input logic [11:0] s2,
                          input logic [11:0] d, input logic [15:0] imm,
                          output int lat, output logic e);
    @(negedge Clk);
    trace.delete();
    inst_op = op; inst_src1 = s1; inst_src2 = s2; inst_dest = d; inst_imm = imm;
    inst_valid = 1'b1;
    @(posedge Clk);
    #1 inst_valid = 1'b0;
    lat = -1;
    e = 1'bx;
    for (int i = 1; i <= 40; i++) begin
      @(negedge Clk);
      if (done) begin
        lat = i;
        e = err;
        break;
      end
    end
  endtask

  int   lat;
  logic e;
  mat_t m_in, m_exp;
  logic found;
  int   d1, d2, rdy_viol;
  logic rdy12;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    inst_valid = 1'b0; inst_op = '0; inst_src1 = '0; inst_src2 = '0;
    inst_dest = '0; inst_imm = '0;
    for (int i = 0; i < 4096; i++) mem[i] = '0;

    #1 nReset = 1'b0;
    repeat (2) @(negedge Clk);
    check("rst_inst_ready", inst_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_strobes", {nRead, nWrite}, 2'b11);
    check("rst_address", address, 16'h0000);
    check("rst_exedata", ExeDataOut, '0);
    nReset = 1'b1;

    // ADD
    mem[12'h010] = fill_mat(16'h0001);
    mem[12'h020] = fill_mat(16'h0002);
    run_inst(4'd1, 12'h010, 12'h020, 12'h030, 16'h0, lat, e);
    check("add_latency", lat, 11);
    check("add_err", e, 1'b0);
    check("add_trace_len", trace.size(), 7);
    check("add_trace", trace_vec(),
          {16'h1010, 16'h2000, 16'h1020, 16'h2001, 16'h2013, 16'h2002, 16'h1030});
    check("add_result", mem[12'h030], fill_mat(16'h0003));

    // TRANSPOSE
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        m_in[r][c]  = 16'(r * 4 + c);
        m_exp[r][c] = 16'(c * 4 + r);
      end
    mem[12'h040] = m_in;
    run_inst(4'd3, 12'h040, 12'h000, 12'h050, 16'h0, lat, e);
    check("tr_latency", lat, 8);
    check("tr_err", e, 1'b0);
    check("tr_trace", trace_vec(), {16'h1040, 16'h2000, 16'h2033, 16'h2002, 16'h1050});
    check("tr_result", mem[12'h050], m_exp);

    // Illegal opcode
    run_inst(4'd7, 12'h010, 12'h020, 12'h0F0, 16'h0, lat, e);
    check("ill_latency", lat, 1);
    check("ill_err", e, 1'b1);
    check("ill_no_bus", trace.size(), 0);

    // SCALEIMMEDIATE
    mem[12'h060] = fill_mat(16'h0002);
    mem[12'h070] = fill_mat(16'h0005);
    run_inst(4'd5, 12'h060, 12'h070, 12'h080, 16'h0003, lat, e);
    check("si_err", e, 1'b0);
`ifdef MATRIX_SEQ_IMM_EN
    check("si_latency", lat, 9);
    check("si_trace", trace_vec(),
          {16'h1060, 16'h2000, 16'h2001, 16'h2053, 16'h2002, 16'h1080});
    check("si_ld2_data", ld2_data, {240'b0, 16'h0003});
    check("si_result", mem[12'h080], fill_mat(16'h0006));
`else
    check("si_latency", lat, 11);
    check("si_trace", trace_vec(),
          {16'h1060, 16'h2000, 16'h1070, 16'h2001, 16'h2053, 16'h2002, 16'h1080});
    check("si_ld2_data", ld2_data, fill_mat(16'h0005));
    check("si_result", mem[12'h080], fill_mat(16'h000A));
`endif

    // Reset during LD2
    mem[12'h090] = fill_mat(16'hDEAD);
    @(negedge Clk);
    inst_op = 4'd1; inst_src1 = 12'h010; inst_src2 = 12'h020; inst_dest = 12'h090;
    inst_valid = 1'b1;
    @(posedge Clk);
    #1 inst_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (!nWrite && address == 16'h2001) begin
        found = 1'b1;
        break;
      end
    end
    check("rm_reached_ld2", found, 1'b1);
    #1 nReset = 1'b0;
    #1;
    check("rm_address", address, 16'h0000);
    check("rm_strobes", {nRead, nWrite}, 2'b11);
    check("rm_exedata", ExeDataOut, '0);
    check("rm_inst_ready", inst_ready, 1'b1);
    @(negedge Clk);
    nReset = 1'b1;
    repeat (3) @(negedge Clk);
    check("rm_no_write", mem[12'h090], fill_mat(16'hDEAD));
    run_inst(4'd1, 12'h010, 12'h020, 12'h0A0, 16'h0, lat, e);
    check("rm_next_latency", lat, 11);
    check("rm_next_result", mem[12'h0A0], fill_mat(16'h0003));

    // Back-to-back with inst_valid held high
    @(negedge Clk);
    inst_op = 4'd1; inst_src1 = 12'h010; inst_src2 = 12'h020; inst_dest = 12'h0B0;
    inst_valid = 1'b1;
    @(posedge Clk);
    d1 = -1; d2 = -1; rdy_viol = 0; rdy12 = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge Clk);
      if (cyc == 1) begin
        inst_op = 4'd2; inst_src1 = 12'h020; inst_src2 = 12'h010; inst_dest = 12'h0C0;
      end
      if (cyc == 13) inst_valid = 1'b0;
      if ((cyc <= 11 || (cyc >= 13 && cyc <= 22)) && inst_ready) rdy_viol++;
      if (cyc == 12) rdy12 = inst_ready;
      if (done && d1 < 0) d1 = cyc;
      else if (done) begin
        d2 = cyc;
        break;
      end
    end
    inst_valid = 1'b0;
    check("b2b_first_done", d1, 11);
    check("b2b_second_done", d2, 23);
    check("b2b_ready_idle", rdy12, 1'b1);
    check("b2b_ready_busy", rdy_viol, 0);
    check("b2b_result1", mem[12'h0B0], fill_mat(16'h0003));
    check("b2b_result2", mem[12'h0C0], fill_mat(16'h0001));

    check("bus_protocol", bus_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
